// File: rtl/adc_pkg.sv
// Shared types and constants for the comparator-based SAR ADC path.
package adc_pkg;

  localparam int ADC_DATA_W = 8;
  localparam int PWM_PERIOD = 256;

  typedef enum logic [2:0] {
    IDLE,
    SET_BIT,
    SETTLE,
    SAMPLE,
    DONE
  } sar_state_t;

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM DAC channel: registered pwm_out = (cnt < duty), plus a
// pulse on the last count of each period so callers can count full periods.
module pwm_gen
  import adc_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] duty,
  output logic              pwm_out,
  output logic              wrap
);

  logic [DATA_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      pwm_out <= 1'b0;
    end else begin
      cnt     <= cnt + 1'b1;
      pwm_out <= (cnt < duty);
    end
  end

  // High during the cycle whose count is all-ones; the next cycle starts a new period.
  assign wrap = (cnt == {DATA_W{1'b1}});

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: drives a PWM DAC, waits for the RC
// filter to settle, and resolves one bit per trial against the comparator.
module sar_adc_ctrl
  import adc_pkg::*;
#(
  parameter int DATA_W         = ADC_DATA_W,
  parameter int SETTLE_PERIODS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              comparator_in,
  output logic              pwm_out,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              result_valid
);

  localparam int BIT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  sar_state_t        state, state_nxt;
  logic              sync_q1, comp_s;
  logic [DATA_W-1:0] duty;
  logic [DATA_W-1:0] sar;
  logic [BIT_W-1:0]  bit_idx;
  logic [7:0]        settle_cnt;
  logic              wrap;
  logic              settle_last;

  pwm_gen #(.DATA_W(DATA_W)) u_pwm (
    .clk     (clk),
    .reset   (reset),
    .duty    (duty),
    .pwm_out (pwm_out),
    .wrap    (wrap)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= 1'b0;
      comp_s  <= 1'b0;
    end else begin
      sync_q1 <= comparator_in;
      comp_s  <= sync_q1;
    end
  end

  // The wrap that brings the period count up to SETTLE_PERIODS ends settling.
  assign settle_last = wrap && (settle_cnt == 8'(SETTLE_PERIODS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SET_BIT;
      SET_BIT: state_nxt = SETTLE;
      SETTLE:  if (settle_last) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (bit_idx == '0) ? DONE : SET_BIT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SET_BIT) || (state == SETTLE) || (state == SAMPLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty         <= '0;
      sar          <= '0;
      bit_idx      <= BIT_W'(DATA_W - 1);
      settle_cnt   <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sar          <= '0;
            bit_idx      <= BIT_W'(DATA_W - 1);
            result_valid <= 1'b0;
          end
        end
        SET_BIT: begin
          duty       <= sar | (DATA_W'(1) << bit_idx);
          settle_cnt <= '0;
        end
        SETTLE: begin
          if (wrap) settle_cnt <= settle_cnt + 8'd1;
        end
        SAMPLE: begin
          // Trial code still applied to the DAC is the candidate to keep.
          if (comp_s) sar <= duty;
          if (bit_idx != '0) bit_idx <= bit_idx - 1'b1;
        end
        DONE: begin
          result       <= sar;
          result_valid <= 1'b1;
          duty         <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl with an ideal-filter comparator model.
module tb_sar_adc_ctrl;

  localparam int DW    = 8;
  localparam int SP    = 2;
  localparam int BOUND = DW * (SP * 256 + 2) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          comparator_in = 1'b0;
  logic          pwm_out;
  logic          busy;
  logic          done;
  logic [DW-1:0] result;
  logic          result_valid;

  int            tests = 0;
  int            fails = 0;
  int            done_cnt = 0;
  logic [7:0]    model_a = 8'h00;
  bit            glitch_en = 1'b0;

  sar_adc_ctrl #(.DATA_W(DW), .SETTLE_PERIODS(SP)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .comparator_in (comparator_in),
    .pwm_out       (pwm_out),
    .busy          (busy),
    .done          (done),
    .result        (result),
    .result_valid  (result_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Ideal RC filter: comparator sees the applied duty; optionally noisy
  // except in the window just before each period boundary (where SAMPLE falls).
  always @(negedge clk) begin
    if (glitch_en && !(dut.u_pwm.cnt >= 8'd248 || dut.u_pwm.cnt <= 8'd3))
      comparator_in = 1'($urandom_range(0, 1));
    else
      comparator_in = (model_a >= dut.duty);
  end

  task automatic run_conv(input logic [7:0] a, output int lat, output bit ok);
    model_a = a;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < BOUND + 8) begin
      @(negedge clk);
      lat++;
    end
    ok = (done === 1'b1);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (result !== 8'h00) begin fails++; $display("FAIL reset_result got %h want 00", result); end
    tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", result_valid); end
    tests++; if (pwm_out !== 1'b0) begin fails++; $display("FAIL reset_pwm got %b want 0", pwm_out); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_pwm();
    int highs;
    int lat;
    model_a = 8'h80;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      if (pwm_out === 1'b1) highs++;
      @(negedge clk);
    end
    tests++; if (highs != 128) begin fails++; $display("FAIL pwm_duty80 got %0d highs want 128", highs); end
    lat = 0;
    while (done !== 1'b1 && lat < BOUND + 8) begin @(negedge clk); lat++; end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL pwm_conv_timeout got done=%b want 1", done); end
    @(negedge clk);
    tests++; if (result !== 8'h80) begin fails++; $display("FAIL pwm_result got %h want 80", result); end
    repeat (2) @(negedge clk);
    highs = 0;
    for (int i = 0; i < 300; i++) begin
      if (pwm_out !== 1'b0) highs++;
      @(negedge clk);
    end
    tests++; if (highs != 0) begin fails++; $display("FAIL pwm_idle got %0d highs want 0", highs); end
  endtask

  task automatic test_busy_start();
    int d0;
    int lat;
    model_a = 8'h33;
    // Align so a period boundary falls before cycle 100: a restart would then
    // cost a full extra period and push latency past the bound.
    lat = 0;
    while (dut.u_pwm.cnt != 8'd200 && lat < 600) begin @(negedge clk); lat++; end
    d0 = done_cnt;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 1;
    repeat (99) begin @(negedge clk); lat++; end
    start = 1'b1;
    @(negedge clk); start = 1'b0; lat++;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL busystart_busy got %b want 1", busy); end
    while (done !== 1'b1 && lat < BOUND + 8) begin @(negedge clk); lat++; end
    tests++; if (lat > BOUND) begin fails++; $display("FAIL busystart_latency got %0d want <= %0d", lat, BOUND); end
    repeat (600) @(negedge clk);
    tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL busystart_dones got %0d want 1", done_cnt - d0); end
    tests++; if (result !== 8'h33) begin fails++; $display("FAIL busystart_result got %h want 33", result); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL busystart_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_sweep();
    logic [7:0] vals [4];
    int lat;
    int d0;
    bit ok;
    vals[0] = 8'h00; vals[1] = 8'hFF; vals[2] = 8'h80; vals[3] = 8'h5A;
    for (int k = 0; k < 4; k++) begin
      d0 = done_cnt;
      run_conv(vals[k], lat, ok);
      tests++; if (!ok) begin fails++; $display("FAIL sweep_timeout a=%h got no done want done", vals[k]); end
      tests++; if (result !== vals[k]) begin fails++; $display("FAIL sweep_result got %h want %h", result, vals[k]); end
      tests++; if (result_valid !== 1'b1) begin fails++; $display("FAIL sweep_valid a=%h got %b want 1", vals[k], result_valid); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL sweep_busy a=%h got %b want 0", vals[k], busy); end
      tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL sweep_dones a=%h got %0d want 1", vals[k], done_cnt - d0); end
    end
  endtask

  task automatic test_reset_mid();
    int w;
    int lat;
    bit ok;
    model_a = 8'hC0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    w = 0;
    while (dut.bit_idx != 3'd4 && w < BOUND) begin @(negedge clk); w++; end
    repeat (10) @(negedge clk);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rstmid_pre_busy got %b want 1", busy); end
    #2 reset = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", busy); end
    tests++; if (result !== 8'h00) begin fails++; $display("FAIL rstmid_result got %h want 00", result); end
    tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid got %b want 0", result_valid); end
    tests++; if (pwm_out !== 1'b0) begin fails++; $display("FAIL rstmid_pwm got %b want 0", pwm_out); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    run_conv(8'hC0, lat, ok);
    tests++; if (!ok || result !== 8'hC0) begin fails++; $display("FAIL rstmid_after got %h ok=%0d want c0", result, ok); end
  endtask

  task automatic test_glitch();
    int lat;
    bit ok;
    glitch_en = 1'b1;
    run_conv(8'hA7, lat, ok);
    glitch_en = 1'b0;
    tests++; if (!ok) begin fails++; $display("FAIL glitch_timeout got no done want done"); end
    tests++; if (result !== 8'hA7) begin fails++; $display("FAIL glitch_result got %h want a7", result); end
  endtask

  initial begin
    test_reset();
    test_pwm();
    test_busy_start();
    test_sweep();
    test_reset_mid();
    test_glitch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
